trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Machine-mode trap sequencer for the RV32 core.
- Takes the decoded ecall/mret strobes and an illegal-instruction strobe for the instruction in execute. Owns the M-mode trap CSRs: mstatus (MIE/MPIE/MPP), mtvec, mepc, mcause.
- Runs a fixed multi-cycle flush/redirect sequence so fetch restarts at the trap vector or the saved PC.
- Sits between the decode stage and the PC/fetch unit; also services CSR reads and writes.

Parameters:
- XLEN, 32, data/address width.
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset; bits [1:0] ignored.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  instruction in execute is valid.
- i_pc  input  XLEN  PC of the execute instruction.
- i_ecall  input  1  decoded ecall.
- i_mret  input  1  decoded mret.
- i_illegal  input  1  illegal/unsupported instruction.
- i_csr_we  input  1  CSR write strobe.
- i_csr_addr  input  12  CSR address, used for both read and write.
- i_csr_wdata  input  XLEN  CSR write data.
- o_csr_rdata  output  XLEN  combinational CSR read data.
- o_stall  output  1  freeze fetch/decode/execute.
- o_flush  output  1  kill younger in-flight instructions.
- o_redirect  output  1  load o_redirect_pc into the PC.
- o_redirect_pc  output  XLEN  redirect target.
- o_busy  output  1  FSM not in IDLE.

Behaviour:
- Clock and reset: single clock i_clk. Reset is asynchronous and active-low on i_rst_n.

Reset values:
- State IDLE.
- mstatus.MIE=0, mstatus.MPIE=0; MPP hardwired 2'b11.
- mtvec = {RESET_MTVEC[31:2], 2'b00}.
- mepc = 0, mcause = 0.
- o_stall, o_flush, o_redirect, o_busy = 0; o_redirect_pc = 0.

Event qualification (sampled only in IDLE with i_valid=1):
- i_illegal=1, or i_ecall and i_mret both 1: TRAP with cause 2.
- Else i_ecall=1: TRAP with cause 11.
- Else i_mret=1: MRET.
- Else: no event.

FSM:
- IDLE: on an event at edge N, latch kind, cause and i_pc, then go to FLUSH.
- FLUSH (cycle N+1): o_stall=1, o_flush=1, o_busy=1. At the end of this cycle, commit the CSR updates and go to REDIRECT.
  - TRAP: mepc <= {pc[31:2], 2'b00}; mcause <= cause; MPIE <= MIE; MIE <= 0.
  - MRET: MIE <= MPIE; MPIE <= 1; mepc and mcause unchanged.
- REDIRECT (cycle N+2): o_redirect=1, o_busy=1, o_stall=0, o_flush=0. Go to IDLE at the end of the cycle.
  - o_redirect_pc = mtvec for TRAP.
  - o_redirect_pc = mepc for MRET.
- Total: exactly one FLUSH cycle and one REDIRECT cycle per event. Latency from accepting edge to redirect is 2 cycles.
- o_redirect_pc holds its last value outside REDIRECT.

CSR access:
- Read is combinational on i_csr_addr:
  - 0x300: mstatus, with MIE at bit 3, MPIE at bit 7, bits [12:11]=2'b11, all other bits 0.
  - 0x305: mtvec.
  - 0x341: mepc.
  - 0x342: mcause.
  - Any other address reads 0.
- Write is accepted only in IDLE, and only when no event is accepted the same cycle. A trapping instruction's write is dropped.
- Write field rules:
  - mtvec and mepc: bits [1:0] forced to 0.
  - mstatus: only MIE and MPIE are writable.
  - mcause: full width writable.
  - Writes to unimplemented addresses are ignored.

Boundary conditions:
- Events and CSR writes in FLUSH/REDIRECT are ignored; the pipeline is stalled, so the upstream stage must hold or drop them.
- i_valid=0 masks all strobes.
- Back-to-back: an event may be accepted in the IDLE cycle immediately after REDIRECT.
- Reset asserted mid-sequence: immediate return to IDLE, all outputs 0, CSRs to reset values. No redirect is issued.
- An event arriving the same cycle as reset deassertion is accepted only on a clock edge where i_rst_n=1.

Test Plan:
- Reset then read CSRs: with RESET_MTVEC=0x100, reading 0x305 returns 0x100 and 0x300 returns 0x1800. All outputs 0.
- ecall at pc=0x2004 with MIE=1: FLUSH cycle with stall=1, flush=1; next cycle redirect=1, redirect_pc=0x100. Then mepc=0x2004, mcause=11, mstatus=0x1880.
- Following mret: 2 cycles later redirect_pc=0x2004 and mstatus=0x1888. mepc and mcause unchanged.
- i_ecall=i_mret=1, or i_illegal=1, at pc=0x3000: redirect to mtvec, mcause=2, mepc=0x3000.
- CSR write to mtvec of 0x207 in IDLE reads back 0x204. The same write issued together with an ecall is dropped, and the redirect goes to the old mtvec. Strobes in FLUSH/REDIRECT produce no second sequence.
- Assert i_rst_n=0 during FLUSH: o_redirect never pulses, state returns to IDLE, and CSRs return to reset values.

Source files
------------

// File: rtl/trap_controller_if.sv
// Trap controller bus: decode-stage strobes, CSR access and PC redirect.
//   master : pipeline side. It drives the strobes, the PC and the CSR write
//            fields, and it receives the read data, stall, flush and redirect.
//   slave  : trap_controller side.
interface trap_controller_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic [XLEN-1:0] i_pc;
  logic            i_ecall;
  logic            i_mret;
  logic            i_illegal;
  logic            i_csr_we;
  logic [11:0]     i_csr_addr;
  logic [XLEN-1:0] i_csr_wdata;
  logic [XLEN-1:0] o_csr_rdata;
  logic            o_stall;
  logic            o_flush;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirect_pc;
  logic            o_busy;

  modport master (
    output i_valid, i_pc, i_ecall, i_mret, i_illegal,
    output i_csr_we, i_csr_addr, i_csr_wdata,
    input  o_csr_rdata, o_stall, o_flush, o_redirect, o_redirect_pc, o_busy
  );

  modport slave (
    input  i_valid, i_pc, i_ecall, i_mret, i_illegal,
    input  i_csr_we, i_csr_addr, i_csr_wdata,
    output o_csr_rdata, o_stall, o_flush, o_redirect, o_redirect_pc, o_busy
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer for the RV32 core.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : trap_controller_if.slave. It carries the strobes and PC of the
//             instruction in execute, CSR read/write access, and the
//             stall/flush/redirect controls to fetch.
// The module owns mstatus (MIE/MPIE, MPP fixed at M), mtvec, mepc and mcause.
// Every event runs exactly one FLUSH cycle and then one REDIRECT cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for an event; CSR writes are accepted here
// FLUSH    | stall and flush the pipe; CSR updates commit at cycle end
// REDIRECT | o_redirect pulses with the mtvec or mepc target
module trap_controller #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  trap_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));
  localparam logic [3:0]      CAUSE_ILL  = 4'd2;
  localparam logic [3:0]      CAUSE_ECALL = 4'd11;

  state_t          state;
  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;

  logic            kind_trap;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] pc_q;

  logic            stall_q;
  logic            flush_q;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            ev_any;
  logic            ev_trap;
  logic [3:0]      ev_cause;
  logic            csr_wr_en;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] rdata;

  // An illegal instruction, or ecall and mret together, traps with cause 2.
  // An ecall alone traps with cause 11. An mret alone returns.
  always_comb begin
    ev_any   = bus.i_valid & (bus.i_ecall | bus.i_mret | bus.i_illegal);
    ev_trap  = bus.i_illegal | bus.i_ecall;
    ev_cause = (bus.i_illegal | bus.i_mret) ? CAUSE_ILL : CAUSE_ECALL;
    // A write that arrives with an event belongs to the trapping instruction,
    // so it is dropped.
    csr_wr_en = (state == ST_IDLE) & bus.i_valid & bus.i_csr_we & ~ev_any;
  end

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie;
    mstatus_val[3]     = mie;
    unique case (bus.i_csr_addr)
      ADDR_MSTATUS: rdata = mstatus_val;
      ADDR_MTVEC:   rdata = mtvec;
      ADDR_MEPC:    rdata = mepc;
      ADDR_MCAUSE:  rdata = mcause;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      mie           <= 1'b0;
      mpie          <= 1'b0;
      mtvec         <= RESET_MTVEC & ALIGN_MASK;
      mepc          <= '0;
      mcause        <= '0;
      kind_trap     <= 1'b0;
      cause_q       <= '0;
      pc_q          <= '0;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ev_any) begin
            kind_trap <= ev_trap;
            cause_q   <= ev_cause;
            pc_q      <= bus.i_pc & ALIGN_MASK;
            stall_q   <= 1'b1;
            flush_q   <= 1'b1;
            state     <= ST_FLUSH;
          end else if (csr_wr_en) begin
            unique case (bus.i_csr_addr)
              ADDR_MSTATUS: begin
                mie  <= bus.i_csr_wdata[3];
                mpie <= bus.i_csr_wdata[7];
              end
              ADDR_MTVEC:  mtvec  <= bus.i_csr_wdata & ALIGN_MASK;
              ADDR_MEPC:   mepc   <= bus.i_csr_wdata & ALIGN_MASK;
              ADDR_MCAUSE: mcause <= bus.i_csr_wdata;
              default: ;
            endcase
          end
        end
        ST_FLUSH: begin
          stall_q    <= 1'b0;
          flush_q    <= 1'b0;
          redirect_q <= 1'b1;
          // No CSR write can land during the sequence, so mtvec and mepc are
          // stable here. That lets the target register in the same cycle as
          // the commit.
          if (kind_trap) begin
            mepc          <= pc_q;
            mcause        <= XLEN'(cause_q);
            mpie          <= mie;
            mie           <= 1'b0;
            redirect_pc_q <= mtvec;
          end else begin
            mie           <= mpie;
            mpie          <= 1'b1;
            redirect_pc_q <= mepc;
          end
          state <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          redirect_q <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_csr_rdata   = rdata;
  assign bus.o_stall       = stall_q;
  assign bus.o_flush       = flush_q;
  assign bus.o_redirect    = redirect_q;
  assign bus.o_redirect_pc = redirect_pc_q;
  assign bus.o_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// Testbench for trap_controller. Expected redirect targets are queued when an
// event is issued. A negedge monitor pops one expected target per redirect
// pulse and compares it.
module tb_trap_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_q[$];
  logic        prev_flush = 1'b0;

  trap_controller_if #(.XLEN(32)) bus ();

  trap_controller #(.XLEN(32), .RESET_MTVEC(32'h0000_0100)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Every redirect must match the queued target and must directly follow a
  // FLUSH cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.o_redirect) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_redirect actual=%h required=none", bus.o_redirect_pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.o_redirect_pc !== e || !prev_flush || bus.o_stall) begin
          bad++;
          $display("FAIL redirect_pc actual=%h required=%h prev_flush=%b stall=%b",
                   bus.o_redirect_pc, e, prev_flush, bus.o_stall);
        end
      end
    end
    prev_flush = bus.o_flush;
  end

  task automatic clear_in();
    bus.i_valid = 0; bus.i_pc = '0; bus.i_ecall = 0; bus.i_mret = 0;
    bus.i_illegal = 0; bus.i_csr_we = 0; bus.i_csr_wdata = '0;
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] req);
    bus.i_csr_addr = addr;
    #1;
    chk(name, bus.o_csr_rdata, req);
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    bus.i_valid = 1; bus.i_csr_we = 1; bus.i_csr_addr = addr; bus.i_csr_wdata = data;
    @(posedge clk); #1;
    clear_in();
  endtask

  // Issue one event. The FLUSH cycle outputs are checked here, and the
  // redirect itself is checked by the monitor.
  task automatic ev(input string name, input logic [31:0] pc, input logic e, input logic m,
                    input logic il, input logic [31:0] target);
    bus.i_valid = 1; bus.i_pc = pc; bus.i_ecall = e; bus.i_mret = m; bus.i_illegal = il;
    exp_q.push_back(target);
    @(posedge clk); #1;
    clear_in();
    chk({name, "_flush"}, {29'd0, bus.o_stall, bus.o_flush, bus.o_busy}, 32'h7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({name, "_idle"}, {31'd0, bus.o_busy}, 32'h0);
  endtask

  initial begin
    clear_in();
    bus.i_csr_addr = '0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_outs", {28'd0, bus.o_stall, bus.o_flush, bus.o_redirect, bus.o_busy}, 32'h0);
    chk("rst_rpc", bus.o_redirect_pc, 32'h0);
    rd("rst_mtvec", 12'h305, 32'h100);
    rd("rst_mstatus", 12'h300, 32'h1800);
    rd("rst_mepc", 12'h341, 32'h0);
    rd("rst_mcause", 12'h342, 32'h0);

    csr_wr(12'h300, 32'hFFFF_FF77);
    rd("mstatus_wr_none", 12'h300, 32'h1800);
    csr_wr(12'h300, 32'h0000_0008);
    rd("mstatus_wr_mie", 12'h300, 32'h1808);

    ev("ecall", 32'h2004, 1, 0, 0, 32'h100);
    rd("ecall_mepc", 12'h341, 32'h2004);
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mstatus", 12'h300, 32'h1880);
    chk("rpc_hold", bus.o_redirect_pc, 32'h100);

    ev("mret", 32'h2010, 0, 1, 0, 32'h2004);
    rd("mret_mstatus", 12'h300, 32'h1888);
    rd("mret_mepc", 12'h341, 32'h2004);
    rd("mret_mcause", 12'h342, 32'd11);

    ev("ecall_mret", 32'h3000, 1, 1, 0, 32'h100);
    rd("em_mcause", 12'h342, 32'd2);
    rd("em_mepc", 12'h341, 32'h3000);
    rd("em_mstatus", 12'h300, 32'h1880);

    csr_wr(12'h342, 32'hDEAD_BEEF);
    rd("mcause_wr", 12'h342, 32'hDEAD_BEEF);
    ev("illegal", 32'h3006, 0, 0, 1, 32'h100);
    rd("ill_mcause", 12'h342, 32'd2);
    rd("ill_mepc", 12'h341, 32'h3004);

    bus.i_valid = 0; bus.i_ecall = 1; bus.i_pc = 32'h5000;
    @(posedge clk); #1;
    clear_in();
    chk("valid_mask", {31'd0, bus.o_busy}, 32'h0);
    rd("valid_mask_mepc", 12'h341, 32'h3004);

    csr_wr(12'h305, 32'h207);
    rd("mtvec_wr", 12'h305, 32'h204);
    csr_wr(12'h301, 32'hFFFF_FFFF);
    rd("unimpl_rd", 12'h301, 32'h0);

    bus.i_csr_we = 1; bus.i_csr_addr = 12'h305; bus.i_csr_wdata = 32'h300;
    ev("ecall_wr", 32'h4000, 1, 0, 0, 32'h204);
    rd("dropped_mtvec", 12'h305, 32'h204);

    // Back-to-back: an mret is issued in the first IDLE cycle after REDIRECT.
    ev("b2b_mret", 32'h4100, 0, 1, 0, 32'h4000);

    // Strobes and a CSR write are held through FLUSH and REDIRECT. Only one
    // sequence may result, and the mepc write must be ignored.
    exp_q.push_back(32'h204);
    bus.i_valid = 1; bus.i_pc = 32'h6000; bus.i_ecall = 1;
    bus.i_csr_we = 1; bus.i_csr_addr = 12'h341; bus.i_csr_wdata = 32'h5554;
    repeat (3) @(posedge clk);
    #1;
    clear_in();
    repeat (3) @(posedge clk);
    #1;
    rd("hold_mepc", 12'h341, 32'h6000);
    chk("hold_busy", {31'd0, bus.o_busy}, 32'h0);

    csr_wr(12'h300, 32'h88);
    bus.i_valid = 1; bus.i_pc = 32'h7000; bus.i_ecall = 1;
    @(posedge clk); #1;
    clear_in();
    chk("midrst_flush", {31'd0, bus.o_flush}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {28'd0, bus.o_stall, bus.o_flush, bus.o_redirect, bus.o_busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rd("midrst_mstatus", 12'h300, 32'h1800);
    rd("midrst_mtvec", 12'h305, 32'h100);
    rd("midrst_mepc", 12'h341, 32'h0);
    rd("midrst_mcause", 12'h342, 32'h0);

    // An event is held across a reset edge. It is accepted only on the first
    // edge after rst_n returns high.
    bus.i_valid = 1; bus.i_pc = 32'h8000; bus.i_ecall = 1;
    @(posedge clk); #1;
    chk("rst_event_ignored", {31'd0, bus.o_busy}, 32'h0);
    rst_n = 1'b1;
    ev("post_rst", 32'h8000, 1, 0, 0, 32'h100);
    rd("post_rst_mepc", 12'h341, 32'h8000);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
